i2s_receiver: RTL
=================

# i2s_receiver

I2S slave receiver that sits directly upstream of the PWM generator. It deserialises stereo I2S frames clocked by the bit clock, mixes left and right into one mono sample, and converts it to offset-binary. It then scales the result to the PWM period and presents it as a registered duty-cycle word. A one-cycle strobe marks every update.

## Interface

**Parameters**
- `SAMPLE_BITS`, 16: bits captured per channel slot, MSB first, two's complement.
- `OUT_WIDTH`, 8: width of `duty_cycle`. Must satisfy `OUT_WIDTH` ≤ `SAMPLE_BITS`.
- `DUTY_MAX`, 192: PWM period in clocks. Must satisfy `DUTY_MAX` ≤ 2^`OUT_WIDTH`.

**Ports**
- `clk`, in, 1: I2S bit clock (3.072 MHz, 64 BCLK per frame). All logic runs on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `i2s_ws`, in, 1: word select. 0 = left, 1 = right. Changes on the falling edge of BCLK.
- `i2s_sd`, in, 1: serial data. Changes on the falling edge of BCLK.
- `duty_cycle`, out, `OUT_WIDTH`: registered duty word for the PWM generator.
- `sample_valid`, out, 1: one-cycle pulse, high in the cycle `duty_cycle` takes a new value.
- `frame_err`, out, 1: one-cycle pulse when a slot was shorter than `SAMPLE_BITS`.

## Operation

- **Input sampling:** `i2s_ws` and `i2s_sd` are sampled on every rising edge. `ws_q` holds the previous sampled `i2s_ws`. A WS edge at edge E means `i2s_ws` ≠ `ws_q` at edge E.
- **Slot bit accounting:**
  - The `sd` bit sampled at a WS-edge cycle is the LSB period of the closing slot. It counts toward that slot.
  - A slot spans from the cycle after one WS edge through the cycle of the next WS edge.
- **Per-slot capture:**
  - `bit_cnt` is reset to 0 when a slot opens.
  - While `bit_cnt` < `SAMPLE_BITS`, the sampled `sd` bit is shifted into the shift register and `bit_cnt` increments.
  - When `bit_cnt` = `SAMPLE_BITS`, `bit_cnt` saturates and further bits are ignored. Slots longer than `SAMPLE_BITS` are legal.
- **State machine:**
  - SYNC is the reset state. It ignores data and rising WS edges. A falling WS edge (1→0) moves it to LEFT.
  - LEFT: on a rising WS edge, close the slot.
    - If the slot is complete, store the shift register as `left_s` and set `left_ok`.
    - Otherwise clear `left_ok` and flag an error.
    - Go to RIGHT.
  - RIGHT: on a falling WS edge, close the slot.
    - If the slot is complete and `left_ok` is set, launch the output pipeline with `right_s`.
    - If the slot is short, flag an error.
    - Go to LEFT.
- **Short slot:** a slot is short when `bit_cnt` < `SAMPLE_BITS` at close. The frame is discarded, `frame_err` pulses and `duty_cycle` holds its value.
- **Arithmetic:**
  - `sum` = `left_s` + `right_s`, sign-extended to `SAMPLE_BITS`+1 bits.
  - `mono` = `sum` arithmetic-shifted right by 1, giving `SAMPLE_BITS` bits.
  - `u` = top `OUT_WIDTH` bits of `mono` with the MSB inverted (offset binary, 0 … 2^`OUT_WIDTH`−1).
  - `duty_cycle` = (`u` × `DUTY_MAX`) >> `OUT_WIDTH`. The product is 2·`OUT_WIDTH` bits and is truncated, never rounded. The result range is 0 … `DUTY_MAX`−1.

## Timing

- **Reset values:**
  - `duty_cycle` = `DUTY_MAX`/2 (96, midscale silence).
  - `sample_valid` = 0, `frame_err` = 0.
  - State = SYNC; `left_ok`, `bit_cnt` and shift register cleared.
- **Reset mid-frame:** outputs go to reset values immediately (asynchronously). Capture resumes only after the next 1→0 WS edge.
- **Pipeline latency.** Let E be the rising edge that detects the right-slot-closing 1→0 WS edge.
  - E: `left_s`/`right_s` latched.
  - E+1: `u` registered.
  - E+2: `duty_cycle` updates and `sample_valid` = 1 for exactly one cycle.
- **Error timing:** `frame_err` is registered and high for exactly the one cycle after the closing edge.
- **Throughput:** at most one `sample_valid` per frame (64 BCLK, 48 kHz). The pipeline never stalls.
- **Overlap:** `duty_cycle` is stable between strobes. A new WS edge during pipeline stages E+1/E+2 does not disturb the in-flight sample.

## Test plan

- **Reset:** assert `rst_n`=0 mid-slot → `duty_cycle`=96, `sample_valid`=0, `frame_err`=0. Then release, send one right slot before any 1→0 WS edge → no strobe.
- **Silence:** L=0x0000, R=0x0000, 32-BCLK slots → `sample_valid` pulse exactly 2 cycles after the right-closing WS edge, `duty_cycle`=96.
- **Full scale:**
  - L=R=0x7FFF → `duty_cycle`=191.
  - L=R=0x8000 → `duty_cycle`=0.
  - One strobe per frame, 64 cycles apart.
- **Mix and truncation:** L=0x7FFF, R=0x8000 → `mono`=0xFFFF, `u`=0x7F → `duty_cycle`=95.
- **Short slot:** left slot of 10 BCLK, then a good right slot → `frame_err` one-cycle pulse after the rising WS edge, no `sample_valid`, `duty_cycle` unchanged. The next good frame is accepted normally.
- **Long slots:** 24-BCLK slots with L=R=0x4000 and trailing nonzero bits → trailing bits ignored, `u`=0xC0 → `duty_cycle`=144.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S slave receiver: deserialises stereo frames, mixes to mono, converts to
// offset binary and scales to a registered PWM duty-cycle word.
module i2s_receiver #(
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned DUTY_MAX    = 192
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i2s_ws,
  input  logic                 i2s_sd,
  output logic [OUT_WIDTH-1:0] duty_cycle,
  output logic                 sample_valid,
  output logic                 frame_err
);

  localparam int unsigned CW = $clog2(SAMPLE_BITS + 1);
  localparam int unsigned PW = 2 * OUT_WIDTH;

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  localparam logic [OUT_WIDTH-1:0] DUTY_RST = OUT_WIDTH'(DUTY_MAX / 2);
  localparam logic [OUT_WIDTH-1:0] U_MSB    = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

  logic [1:0]             state_q, state_d;
  logic                   ws_q;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] left_s_q, left_s_d;
  logic [SAMPLE_BITS-1:0] right_s_q, right_s_d;
  logic                   left_ok_q, left_ok_d;
  logic                   launch_q, launch_d;
  logic                   err_q, err_d;
  logic [OUT_WIDTH-1:0]   u_q, u_d;
  logic                   pipe1_q, pipe1_d;
  logic [OUT_WIDTH-1:0]   duty_q, duty_d;
  logic                   valid_q, valid_d;

  logic                   ws_edge_c;
  logic                   cnt_room_c;
  logic [SAMPLE_BITS-1:0] shift_in_c;
  logic [CW-1:0]          cnt_in_c;
  logic                   slot_full_c;
  logic [SAMPLE_BITS:0]   sum_c;
  logic [OUT_WIDTH-1:0]   mono_top_c;
  logic [PW-1:0]          prod_c;

  // The bit sampled on a WS-edge cycle is the LSB of the slot being closed.
  always_comb begin
    ws_edge_c   = (i2s_ws != ws_q);
    cnt_room_c  = (bit_cnt_q < CW'(SAMPLE_BITS));
    shift_in_c  = cnt_room_c ? {shift_q[SAMPLE_BITS-2:0], i2s_sd} : shift_q;
    cnt_in_c    = cnt_room_c ? (bit_cnt_q + CW'(1)) : bit_cnt_q;
    slot_full_c = (cnt_in_c == CW'(SAMPLE_BITS));
  end

  // Slot framing state machine.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = cnt_in_c;
    shift_d   = shift_in_c;
    left_s_d  = left_s_q;
    right_s_d = right_s_q;
    left_ok_d = left_ok_q;
    launch_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        if (ws_edge_c && !i2s_ws) state_d = ST_LEFT;
      end
      ST_LEFT: begin
        if (ws_edge_c && i2s_ws) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = ST_RIGHT;
          if (slot_full_c) begin
            left_s_d  = shift_in_c;
            left_ok_d = 1'b1;
          end else begin
            left_ok_d = 1'b0;
            err_d     = 1'b1;
          end
        end
      end
      ST_RIGHT: begin
        if (ws_edge_c && !i2s_ws) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = ST_LEFT;
          if (slot_full_c) begin
            right_s_d = shift_in_c;
            launch_d  = left_ok_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_SYNC;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    endcase
  end

  // Mix, offset-binary conversion and scaling to the PWM period.
  always_comb begin
    sum_c      = {left_s_q[SAMPLE_BITS-1], left_s_q} + {right_s_q[SAMPLE_BITS-1], right_s_q};
    mono_top_c = OUT_WIDTH'(sum_c >> (SAMPLE_BITS + 1 - OUT_WIDTH));
    prod_c     = PW'(u_q) * PW'(DUTY_MAX);
    u_d        = u_q;
    pipe1_d    = launch_q;
    duty_d     = duty_q;
    valid_d    = pipe1_q;
    if (launch_q) u_d = mono_top_c ^ U_MSB;
    if (pipe1_q) duty_d = OUT_WIDTH'(prod_c >> OUT_WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SYNC;
      ws_q      <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      left_s_q  <= '0;
      right_s_q <= '0;
      left_ok_q <= 1'b0;
      launch_q  <= 1'b0;
      err_q     <= 1'b0;
      u_q       <= '0;
      pipe1_q   <= 1'b0;
      duty_q    <= DUTY_RST;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ws_q      <= i2s_ws;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      left_s_q  <= left_s_d;
      right_s_q <= right_s_d;
      left_ok_q <= left_ok_d;
      launch_q  <= launch_d;
      err_q     <= err_d;
      u_q       <= u_d;
      pipe1_q   <= pipe1_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
    end
  end

  assign duty_cycle   = duty_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule
